uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares one 8N1 UART transmit line between N_REQ byte producers.
- Arbitrates round-robin among pending requesters.
- Captures the winning byte and serialises it LSB-first.
- Bit timing comes from the 16x oversampling tick produced by the baud tick generator.
- Sits between the system-side producers (ALU result, status, debug) and the board TX pin.

Parameters:
N_REQ, 4, number of requesters (2..8)
DATA_BITS, 8, payload bits per frame
TICKS_PER_BIT, 16, baud ticks per start/data bit
SB_TICKS, 16, baud ticks for the stop bit (16 = 1 stop, 32 = 2 stops)
ID_W, clog2(N_REQ), grant index width

Ports:
i_clk  in  1  system clock
i_reset  in  1  asynchronous, active-low reset (asserted when 0)
i_tick  in  1  one-cycle baud tick, 16x baud rate
i_req_valid  in  N_REQ  requester k has a byte pending
i_req_data  in  N_REQ*DATA_BITS  byte of requester k at bits [k*DATA_BITS +: DATA_BITS]
o_req_ready  out  N_REQ  one-cycle accept pulse to the granted requester
o_tx  out  1  serial line, idle high
o_busy  out  1  high from accept cycle until stop bit completes
o_grant  out  ID_W  index of the requester last/currently served

Behaviour:
- Reset (i_reset=0, asynchronous):
  - o_tx=1, o_busy=0, o_req_ready=0, o_grant=0.
  - Round-robin pointer = N_REQ-1, so requester 0 has first priority.
  - FSM=IDLE; tick counter and bit counter = 0; shift register = 0.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - If any i_req_valid, search from pointer+1 upward with wrap.
  - The first valid index k wins. In that same cycle:
    - o_req_ready[k]=1 for exactly one cycle.
    - Shift register <= slice k.
    - o_grant <= k; pointer <= k.
    - o_busy <= 1.
    - Next state START; tick counter cleared.
  - No valid: stay in IDLE, o_tx=1.
- Handshake:
  - A requester holds valid and data stable until it sees ready.
  - Transfer occurs in the cycle where valid&ready.
  - Valid deasserted before grant means the byte is never sent; no error.
  - o_req_ready is never asserted outside IDLE and never for more than one index.
- START: o_tx=0. On each i_tick, increment the tick counter. On the tick where the counter = TICKS_PER_BIT-1: clear the counter, clear the bit counter, go to DATA.
- DATA:
  - o_tx = shift[0].
  - At the end of each bit period (same tick rule), shift right and increment the bit counter.
  - After bit DATA_BITS-1, go to STOP.
- STOP: o_tx=1. On the tick where the counter = SB_TICKS-1, go to IDLE and set o_busy=0.
  - Arbitration is evaluated in the next cycle (IDLE), so back-to-back frames have exactly one clock of idle-high gap plus the partial tick alignment.
- Timing: one frame lasts exactly (1+DATA_BITS)*TICKS_PER_BIT + SB_TICKS ticks after the accept cycle (160 ticks at defaults).
- Counter widths:
  - Tick counter: clog2(max(TICKS_PER_BIT, SB_TICKS)) bits.
  - Bit counter: clog2(DATA_BITS) bits.
  - No counter wraps other than by explicit clear.
- i_tick outside START/DATA/STOP is ignored.
- o_tx is registered, so it is glitch-free.
- Reset mid-frame: o_tx returns to 1 immediately. The frame is truncated and not retried. The pointer returns to N_REQ-1.
- Pending valids during a frame: held off, and arbitrated only in IDLE. A single continuously valid requester is served back-to-back.

Decomposition:
- Shared package (uart_pkg) holds:
  - State encoding localparams (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3).
  - Default TICKS_PER_BIT/SB_TICKS/DATA_BITS constants.
  - The clog2 function.
- One sub-module: rr_arbiter.
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant, index and any_req.
  - Purely combinational.
  - Reusable for a later RX-side consumer mux.

Test Plan:
- Reset, then i_req_valid=4'b0001, data0=8'hA5, tick every 4 clocks:
  - o_req_ready[0] pulses once; o_tx=0 for 16 ticks.
  - Data bits 1,0,1,0,0,1,0,1 for 16 ticks each, then 1 for 16 ticks.
  - o_busy falls after 160 ticks.
- All four valid, data k = 8'h10+k, held until ready:
  - Grants in order 0,1,2,3 and the line carries 10,11,12,13.
  - Re-asserting all valids gives order 0,1,2,3 again.
- Only requester 2 valid continuously with 8'h3C:
  - Consecutive frames; o_grant=2 each time.
  - IDLE gap of at most 1 tick between stop bit and next start.
- Requester 1 raises valid then drops it before STOP of an ongoing frame for requester 0:
  - No ready pulse to 1 and no second frame.
- Assert i_reset=0 in the middle of data bit 4:
  - o_tx=1 in the same cycle; o_busy=0.
  - After release, requester 0 wins first even if the last grant was 3.
- SB_TICKS=32, data 8'hFF:
  - Frame length is 176 ticks; stop high for 32 ticks before the next start.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, default frame constants and width helpers for the UART TX path.
package uart_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;
  localparam int DEF_N_REQ         = 4;
  localparam int DEF_DATA_BITS     = 8;
  localparam int DEF_TICKS_PER_BIT = 16;
  localparam int DEF_SB_TICKS      = 16;
  // Never returns 0 so that single-value counters still get one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; the search starts one above i_ptr and wraps.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int N    = DEF_N_REQ,
  parameter int ID_W = clog2(N)
) (
  input  logic [N-1:0]    i_req,
  input  logic [ID_W-1:0] i_ptr,
  output logic [N-1:0]    o_gnt,
  output logic [ID_W-1:0] o_idx,
  output logic            o_any
);
  logic [ID_W-1:0] w_j;
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = i_ptr;
    for (int k = 0; k < N; k++) begin
      w_j = (w_j == ID_W'(N - 1)) ? '0 : w_j + 1'b1;
      if (!o_any && i_req[w_j]) begin
        o_any       = 1'b1;
        o_gnt[w_j]  = 1'b1;
        o_idx       = w_j;
      end
    end
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin shares one 8N1 TX line among N_REQ byte producers.
// Bit timing is counted in 16x baud ticks; o_tx is registered from next-state values.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ         = DEF_N_REQ,
  parameter int DATA_BITS     = DEF_DATA_BITS,
  parameter int TICKS_PER_BIT = DEF_TICKS_PER_BIT,
  parameter int SB_TICKS      = DEF_SB_TICKS,
  parameter int ID_W          = clog2(N_REQ)
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_tick,
  input  logic [N_REQ-1:0]           i_req_valid,
  input  logic [N_REQ*DATA_BITS-1:0] i_req_data,
  output logic [N_REQ-1:0]           o_req_ready,
  output logic                       o_tx,
  output logic                       o_busy,
  output logic [ID_W-1:0]            o_grant
);
  localparam int TC_W = clog2(max2(TICKS_PER_BIT, SB_TICKS));
  localparam int BC_W = clog2(DATA_BITS);
  state_t                r_state, w_state_nxt;
  logic [TC_W-1:0]       r_tcnt, w_tcnt_nxt;
  logic [BC_W-1:0]       r_bcnt, w_bcnt_nxt;
  logic [DATA_BITS-1:0]  r_shift, w_shift_nxt;
  logic [ID_W-1:0]       r_ptr, w_ptr_nxt, r_grant, w_idx;
  logic [N_REQ-1:0]      w_gnt;
  logic                  r_busy, w_busy_nxt, r_tx, w_tx_nxt, w_any, w_accept;
  rr_arbiter #(.N(N_REQ), .ID_W(ID_W)) u_arb (
    .i_req (i_req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );
  assign w_accept    = (r_state == IDLE) && w_any;
  // Ready is combinational so the transfer lands in the same cycle as the grant.
  assign o_req_ready = (w_accept && i_reset) ? w_gnt : '0;
  assign o_tx        = r_tx;
  assign o_busy      = r_busy;
  assign o_grant     = r_grant;
  always_comb begin
    w_state_nxt = r_state;
    w_tcnt_nxt  = r_tcnt;
    w_bcnt_nxt  = r_bcnt;
    w_shift_nxt = r_shift;
    w_ptr_nxt   = r_ptr;
    w_busy_nxt  = r_busy;
    case (r_state)
      IDLE:
        if (w_any) begin
          w_state_nxt = START;
          w_tcnt_nxt  = '0;
          w_shift_nxt = i_req_data[int'(w_idx)*DATA_BITS +: DATA_BITS];
          w_ptr_nxt   = w_idx;
          w_busy_nxt  = 1'b1;
        end
      START:
        if (i_tick) begin
          if (r_tcnt == TC_W'(TICKS_PER_BIT - 1)) begin
            w_tcnt_nxt  = '0;
            w_bcnt_nxt  = '0;
            w_state_nxt = DATA;
          end else w_tcnt_nxt = r_tcnt + 1'b1;
        end
      DATA:
        if (i_tick) begin
          if (r_tcnt == TC_W'(TICKS_PER_BIT - 1)) begin
            w_tcnt_nxt  = '0;
            w_shift_nxt = r_shift >> 1;
            w_bcnt_nxt  = (r_bcnt == BC_W'(DATA_BITS - 1)) ? '0 : r_bcnt + 1'b1;
            w_state_nxt = (r_bcnt == BC_W'(DATA_BITS - 1)) ? STOP : DATA;
          end else w_tcnt_nxt = r_tcnt + 1'b1;
        end
      STOP:
        if (i_tick) begin
          if (r_tcnt == TC_W'(SB_TICKS - 1)) begin
            w_tcnt_nxt  = '0;
            w_state_nxt = IDLE;
            w_busy_nxt  = 1'b0;
          end else w_tcnt_nxt = r_tcnt + 1'b1;
        end
      default: w_state_nxt = IDLE;
    endcase
    w_tx_nxt = (w_state_nxt == START) ? 1'b0 :
               (w_state_nxt == DATA)  ? w_shift_nxt[0] : 1'b1;
  end
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= IDLE;
      r_tcnt  <= '0;
      r_bcnt  <= '0;
      r_shift <= '0;
      r_ptr   <= ID_W'(N_REQ - 1);
      r_grant <= '0;
      r_busy  <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_tcnt  <= w_tcnt_nxt;
      r_bcnt  <= w_bcnt_nxt;
      r_shift <= w_shift_nxt;
      r_ptr   <= w_ptr_nxt;
      r_grant <= w_accept ? w_idx : r_grant;
      r_busy  <= w_busy_nxt;
      r_tx    <= w_tx_nxt;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: table-driven arbitration/framing vectors plus hand-written corner sequences.
module tb_uart_tx_arbiter;
  typedef struct {
    logic [3:0]  v;
    logic [31:0] d;
    int          idx;
    logic [7:0]  b;
  } vec_t;
  logic        clk = 1'b0, rst_n = 1'b0, tick = 1'b0, sel = 1'b0, prod_en = 1'b0;
  logic [3:0]  valid = '0, valid1 = '0, hold = '0, hold1 = '0;
  logic [31:0] data = '0, data1 = '0;
  logic [3:0]  rdy, rdy1;
  logic        tx, tx1, busy, busy1, tx_s, busy_s;
  logic [1:0]  grant, grant1;
  int          n_checks = 0, n_fail = 0, n_ticks = 0;
  int          rdy_cnt[4] = '{0, 0, 0, 0};
  vec_t        tbl[8];
  uart_tx_arbiter dut (
    .i_clk(clk), .i_reset(rst_n), .i_tick(tick), .i_req_valid(valid), .i_req_data(data),
    .o_req_ready(rdy), .o_tx(tx), .o_busy(busy), .o_grant(grant)
  );
  uart_tx_arbiter #(.SB_TICKS(32)) dut1 (
    .i_clk(clk), .i_reset(rst_n), .i_tick(tick), .i_req_valid(valid1), .i_req_data(data1),
    .o_req_ready(rdy1), .o_tx(tx1), .o_busy(busy1), .o_grant(grant1)
  );
  assign tx_s   = sel ? tx1 : tx;
  assign busy_s = sel ? busy1 : busy;
  always #5 clk = ~clk;
  always @(posedge clk) if (tick) n_ticks <= n_ticks + 1;
  always @(negedge clk) for (int k = 0; k < 4; k++) if (rdy[k]) rdy_cnt[k]++;
  initial begin
    int tc;
    tc = 0;
    forever begin
      @(posedge clk);
      #1;
      tc   = (tc + 1) % 4;
      tick = (tc == 0);
    end
  end
  // Producers hold valid until they see ready, then drop it unless told to keep streaming.
  initial begin
    logic [3:0] seen, seen1;
    forever begin
      @(negedge clk);
      seen  = rdy;
      seen1 = rdy1;
      @(posedge clk);
      #1;
      if (prod_en)
        for (int k = 0; k < 4; k++) begin
          if (seen[k] && !hold[k]) valid[k] = 1'b0;
          if (seen1[k] && !hold1[k]) valid1[k] = 1'b0;
        end
    end
  end
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic wait_rel(input int t0, input int k, inout bit ok);
    int c;
    c = 0;
    while (n_ticks - t0 < k && c < 4000) begin
      @(negedge clk);
      c++;
    end
    if (c >= 4000) ok = 1'b0;
  endtask
  // Samples each bit cell at its first and last tick; ok clears on any framing error or timeout.
  task automatic rx_frame(input int sb, output logic [7:0] d, output int len, output int t0, output bit ok);
    int c, a, b;
    logic v0, v1;
    ok = 1'b1; d = '0; len = 0; t0 = 0; c = 0;
    while (tx_s !== 1'b0 && c < 3000) begin
      @(negedge clk);
      c++;
    end
    if (c >= 3000) begin
      ok = 1'b0;
      return;
    end
    t0 = n_ticks;
    for (int i = 0; i < 10; i++) begin
      a = 16 * i;
      b = (i == 9) ? 144 + sb - 1 : 16 * i + 15;
      wait_rel(t0, a, ok);
      v0 = tx_s;
      wait_rel(t0, b, ok);
      v1 = tx_s;
      if (v0 !== v1) ok = 1'b0;
      if (i == 0 && v0 !== 1'b0) ok = 1'b0;
      if (i == 9 && v0 !== 1'b1) ok = 1'b0;
      if (i >= 1 && i <= 8) d[i-1] = v0;
    end
    c = 0;
    while (busy_s !== 1'b0 && c < 3000) begin
      @(negedge clk);
      c++;
    end
    if (c >= 3000) ok = 1'b0;
    len = n_ticks - t0;
  endtask
  initial begin
    logic [7:0] b;
    int len, t0, pt0, plen, c, r0[4], r1;
    bit ok;
    tbl[0] = '{4'b0001, 32'h000000A5, 0, 8'hA5};
    tbl[1] = '{4'b1111, 32'h13121110, 1, 8'h11};
    tbl[2] = '{4'b0001, 32'h0000005A, 0, 8'h5A};
    tbl[3] = '{4'b1001, 32'hC3000081, 3, 8'hC3};
    tbl[4] = '{4'b1001, 32'hC3000081, 0, 8'h81};
    tbl[5] = '{4'b0110, 32'h00F00F00, 1, 8'h0F};
    tbl[6] = '{4'b0110, 32'h00F00F00, 2, 8'hF0};
    tbl[7] = '{4'b1100, 32'h7E010000, 3, 8'h7E};
    valid = 4'b0001;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_ready", rdy, 0);
    chk("reset_grant", grant, 0);
    chk("reset_tx_sb32", tx1, 1);
    valid = '0;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      valid = tbl[i].v;
      data  = tbl[i].d;
      c = 0;
      @(negedge clk);
      while (rdy == 0 && c < 50) begin
        @(negedge clk);
        c++;
      end
      chk($sformatf("vec%0d_ready", i), rdy, 32'(1) << tbl[i].idx);
      @(posedge clk);
      #1;
      valid = '0;
      rx_frame(16, b, len, t0, ok);
      chk($sformatf("vec%0d_frame_ok", i), ok, 1);
      chk($sformatf("vec%0d_byte", i), b, tbl[i].b);
      chk($sformatf("vec%0d_grant", i), grant, tbl[i].idx);
      chk($sformatf("vec%0d_len", i), len, 160);
    end
    prod_en = 1'b1;
    for (int k = 0; k < 4; k++) r0[k] = rdy_cnt[k];
    for (int r = 0; r < 2; r++) begin
      @(posedge clk);
      #1;
      data  = 32'h13121110;
      valid = 4'b1111;
      for (int f = 0; f < 4; f++) begin
        rx_frame(16, b, len, t0, ok);
        chk($sformatf("rr%0d_%0d_byte", r, f), b, 8'h10 + 8'(f));
        chk($sformatf("rr%0d_%0d_grant", r, f), grant, f);
      end
    end
    for (int k = 0; k < 4; k++) chk($sformatf("rr_ready_count%0d", k), rdy_cnt[k] - r0[k], 2);
    r1 = rdy_cnt[2];
    @(posedge clk);
    #1;
    hold[2] = 1'b1;
    data    = 32'h003C0000;
    valid   = 4'b0100;
    pt0 = 0; plen = 0;
    for (int f = 0; f < 3; f++) begin
      rx_frame(16, b, len, t0, ok);
      chk($sformatf("stream%0d_ok", f), ok, 1);
      chk($sformatf("stream%0d_byte", f), b, 8'h3C);
      chk($sformatf("stream%0d_grant", f), grant, 2);
      if (f > 0) chk($sformatf("stream%0d_gap_le1", f), (t0 - (pt0 + plen)) <= 1, 1);
      pt0 = t0; plen = len;
      if (f == 1) begin
        @(posedge clk);
        #1;
        valid[2] = 1'b0;
        hold[2]  = 1'b0;
      end
    end
    repeat (100) @(posedge clk);
    #1;
    chk("stream_stopped_busy", busy, 0);
    chk("stream_ready_count", rdy_cnt[2] - r1, 3);
    r1 = rdy_cnt[1];
    data  = 32'h00007EA5;
    valid = 4'b0001;
    fork
      rx_frame(16, b, len, t0, ok);
      begin
        repeat (160) @(posedge clk);
        #1;
        valid[1] = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        valid[1] = 1'b0;
      end
    join
    chk("withdraw_byte", b, 8'hA5);
    chk("withdraw_ok", ok, 1);
    repeat (100) @(posedge clk);
    #1;
    chk("withdraw_no_ready", rdy_cnt[1] - r1, 0);
    chk("withdraw_no_frame_busy", busy, 0);
    chk("withdraw_idle_tx", tx, 1);
    data  = 32'h000000E0;
    valid = 4'b0001;
    ok = 1'b1;
    c = 0;
    while (tx !== 1'b0 && c < 100) begin
      @(negedge clk);
      c++;
    end
    t0 = n_ticks;
    wait_rel(t0, 88, ok);
    chk("midframe_wait_ok", ok && c < 100, 1);
    chk("midframe_bit4_tx", tx, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    valid = 4'b0011;
    data  = 32'h0000C35A;
    #1;
    chk("midreset_tx", tx, 1);
    chk("midreset_busy", busy, 0);
    chk("midreset_ready", rdy, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rx_frame(16, b, len, t0, ok);
    chk("after_reset_grant", grant, 0);
    chk("after_reset_byte", b, 8'h5A);
    rx_frame(16, b, len, t0, ok);
    chk("after_reset_next_grant", grant, 1);
    chk("after_reset_next_byte", b, 8'hC3);
    sel      = 1'b1;
    hold1[0] = 1'b1;
    data1    = 32'h000000FF;
    valid1   = 4'b0001;
    rx_frame(32, b, len, t0, ok);
    chk("sb32_ok", ok, 1);
    chk("sb32_byte", b, 8'hFF);
    chk("sb32_len", len, 176);
    pt0 = t0;
    @(posedge clk);
    #1;
    valid1[0] = 1'b0;
    hold1[0]  = 1'b0;
    rx_frame(32, b, len, t0, ok);
    chk("sb32_second_len", len, 176);
    chk("sb32_start_spacing", (t0 - pt0 >= 176) && (t0 - pt0 <= 177), 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
